fetch_parcel_aligner: RTL and testbench

Turns the 32-bit fetch-word stream from instruction memory into one aligned instruction per handshake. It handles 16-bit compressed parcels and 32-bit instructions that span two fetch words, and tracks the instruction PC. It sits between the fetch BRAM return path and decode. Its spanning and compression status outputs drive the IF-stage PC increment logic.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_parcel_aligner.sv | 167 ++++++++++++++++
 tb/tb_fetch_parcel_aligner.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V fetch types, pc increments and parcel decode helper
package riscv_pkg;

    typedef enum logic [1:0] {
        ALIGN_EMPTY,
        ALIGN_LO,
        ALIGN_HI,
        ALIGN_SPAN
    } aligner_state_e;

    localparam int unsigned PcIncrementCompressed = 2;
    localparam int unsigned PcIncrement32bit      = 4;

    function automatic logic is_compressed_parcel(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_parcel_aligner.sv
// rtl/fetch_parcel_aligner.sv - fetch-word to aligned-instruction aligner with pc tracking
// Optional compressed-parcel support is enabled by defining FROST_RVC_EN.
module fetch_parcel_aligner
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_fetch_valid,
    output logic            o_fetch_ready,
    input  logic [31:0]     i_fetch_word,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_is_compressed,
    output logic            o_spanning_wait_for_fetch,
    output logic            o_spanning_in_progress,
    output logic            o_misaligned
);

    aligner_state_e  state_q, state_d;
    logic [31:0]     word_q, word_d;
    logic [15:0]     span_q, span_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            start_hi_q, start_hi_d;
    logic            misaligned_q, misaligned_d;

    logic            lo_c, hi_c;
    logic            instr_valid_raw;
    logic            hs, consume, hi_wait, fetch_acc;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = i_redirect_pc[0];

`ifdef FROST_RVC_EN
    localparam bit RvcEn = 1'b1;
    assign lo_c = is_compressed_parcel(word_q[15:0]);
    assign hi_c = is_compressed_parcel(word_q[31:16]);
`else
    localparam bit RvcEn = 1'b0;
    assign lo_c = 1'b0;
    assign hi_c = 1'b0;
`endif

    always_comb begin
        instr_valid_raw = 1'b0;
        o_instr         = '0;
        case (state_q)
            ALIGN_LO: begin
                instr_valid_raw = 1'b1;
                o_instr         = lo_c ? {16'b0, word_q[15:0]} : word_q;
            end
            ALIGN_HI: begin
                instr_valid_raw = hi_c;
                o_instr         = hi_c ? {16'b0, word_q[31:16]} : 32'b0;
            end
            ALIGN_SPAN: begin
                instr_valid_raw = 1'b1;
                o_instr         = {word_q[15:0], span_q};
            end
            default: ;
        endcase
    end

    assign o_instr_valid = instr_valid_raw & ~i_redirect;
    assign hs            = o_instr_valid & i_instr_ready;
    assign consume       = hs & (((state_q == ALIGN_LO) & ~lo_c) | ((state_q == ALIGN_HI) & hi_c));
    assign hi_wait       = (state_q == ALIGN_HI) & ~hi_c;
    // A misaligned target cannot be fetched from without RVC, so intake stays closed.
    assign o_fetch_ready = ~i_redirect &
                           (((state_q == ALIGN_EMPTY) & ~misaligned_q) | hi_wait | consume);
    assign fetch_acc     = o_fetch_ready & i_fetch_valid;

    assign o_instr_pc   = pc_q;
    assign o_misaligned = misaligned_q;

`ifdef FROST_RVC_EN
    assign o_is_compressed           = ((state_q == ALIGN_LO) & lo_c) | ((state_q == ALIGN_HI) & hi_c);
    assign o_spanning_wait_for_fetch = hi_wait;
    assign o_spanning_in_progress    = (state_q == ALIGN_SPAN);
`else
    assign o_is_compressed           = 1'b0;
    assign o_spanning_wait_for_fetch = 1'b0;
    assign o_spanning_in_progress    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        span_d       = span_q;
        pc_d         = pc_q;
        start_hi_d   = start_hi_q;
        misaligned_d = misaligned_q;
        if (i_redirect) begin
            state_d      = ALIGN_EMPTY;
            pc_d         = {i_redirect_pc[XLEN-1:1], 1'b0};
            start_hi_d   = RvcEn & i_redirect_pc[1];
            misaligned_d = misaligned_q | (~RvcEn & i_redirect_pc[1]);
        end else begin
            case (state_q)
                ALIGN_EMPTY: begin
                    if (fetch_acc) begin
                        word_d     = i_fetch_word;
                        state_d    = start_hi_q ? ALIGN_HI : ALIGN_LO;
                        start_hi_d = 1'b0;
                    end
                end
                ALIGN_LO: begin
                    if (hs && lo_c) begin
                        state_d = ALIGN_HI;
                        pc_d    = pc_q + XLEN'(PcIncrementCompressed);
                    end else if (hs) begin
                        pc_d = pc_q + XLEN'(PcIncrement32bit);
                    end
                end
                ALIGN_HI: begin
                    if (hi_c) begin
                        if (hs) pc_d = pc_q + XLEN'(PcIncrementCompressed);
                    end else if (fetch_acc) begin
                        span_d  = word_q[31:16];
                        word_d  = i_fetch_word;
                        state_d = ALIGN_SPAN;
                    end
                end
                ALIGN_SPAN: begin
                    if (hs) begin
                        state_d = ALIGN_HI;
                        pc_d    = pc_q + XLEN'(PcIncrement32bit);
                    end
                end
                default: state_d = ALIGN_EMPTY;
            endcase
            // Consuming the last parcel of a word refills back-to-back when possible.
            if (consume) begin
                if (i_fetch_valid) begin
                    word_d  = i_fetch_word;
                    state_d = ALIGN_LO;
                end else begin
                    state_d = ALIGN_EMPTY;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ALIGN_EMPTY;
            word_q       <= '0;
            span_q       <= '0;
            pc_q         <= '0;
            start_hi_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            span_q       <= span_d;
            pc_q         <= pc_d;
            start_hi_q   <= start_hi_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_fetch_parcel_aligner.sv
// tb/tb_fetch_parcel_aligner.sv - scoreboard bench for fetch_parcel_aligner (both FROST_RVC_EN builds)
module tb_fetch_parcel_aligner;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_fetch_valid;
    logic        o_fetch_ready;
    logic [31:0] i_fetch_word;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_is_compressed;
    logic        o_spanning_wait_for_fetch;
    logic        o_spanning_in_progress;
    logic        o_misaligned;

    always #5 i_clk = ~i_clk;

    fetch_parcel_aligner #(.XLEN(32)) dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .i_redirect                (i_redirect),
        .i_redirect_pc             (i_redirect_pc),
        .i_fetch_valid             (i_fetch_valid),
        .o_fetch_ready             (o_fetch_ready),
        .i_fetch_word              (i_fetch_word),
        .o_instr_valid             (o_instr_valid),
        .i_instr_ready             (i_instr_ready),
        .o_instr                   (o_instr),
        .o_instr_pc                (o_instr_pc),
        .o_is_compressed           (o_is_compressed),
        .o_spanning_wait_for_fetch (o_spanning_wait_for_fetch),
        .o_spanning_in_progress    (o_spanning_in_progress),
        .o_misaligned              (o_misaligned)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        comp;
        logic        span;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic comp,
                        input logic span);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.comp  = comp;
        e.span  = span;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        tick();
        i_redirect    = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] w);
        logic ok;
        ok            = 1'b0;
        i_fetch_valid = 1'b1;
        i_fetch_word  = w;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge i_clk);
            ok = o_fetch_ready;
            tick();
        end
        i_fetch_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_timeout: word %08h never accepted, required acceptance", w);
        end
    endtask

    task automatic drain;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick();
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && !i_redirect && o_instr_valid && i_instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got %08h @%08h required none", o_instr, o_instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", 64'(o_instr), 64'(e.instr));
                    check("instr_pc", 64'(o_instr_pc), 64'(e.pc));
                    check("is_compressed", 64'(o_is_compressed), 64'(e.comp));
                    check("spanning_in_progress", 64'(o_spanning_in_progress), 64'(e.span));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    logic [31:0] b2b_words [4];
    logic        seen;

    initial begin
        i_rst_n       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_fetch_valid = 1'b0;
        i_fetch_word  = '0;
        i_instr_ready = 1'b1;
        b2b_words[0]  = 32'h0010_0093;
        b2b_words[1]  = 32'h0020_0113;
        b2b_words[2]  = 32'h0030_0193;
        b2b_words[3]  = 32'h0040_0213;

        repeat (2) @(negedge i_clk);
        check("rst_fetch_ready", 64'(o_fetch_ready), 64'd1);
        check("rst_instr_valid", 64'(o_instr_valid), 64'd0);
        check("rst_instr", 64'(o_instr), 64'd0);
        check("rst_instr_pc", 64'(o_instr_pc), 64'd0);
        check("rst_compressed", 64'(o_is_compressed), 64'd0);
        check("rst_span_wait", 64'(o_spanning_wait_for_fetch), 64'd0);
        check("rst_span_prog", 64'(o_spanning_in_progress), 64'd0);
        check("rst_misaligned", 64'(o_misaligned), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // 32-bit then a word whose low parcel is compressed in the RVC build
        redirect(32'h0000_0100);
`ifdef FROST_RVC_EN
        push(32'h00A3_0513, 32'h0000_0100, 1'b0, 1'b0);
        push(32'h0000_4501, 32'h0000_0104, 1'b1, 1'b0);
        push(32'h0000_0000, 32'h0000_0106, 1'b1, 1'b0);
`else
        push(32'h00A3_0513, 32'h0000_0100, 1'b0, 1'b0);
        push(32'h0000_4501, 32'h0000_0104, 1'b0, 1'b0);
`endif
        fetch(32'h00A3_0513);
        fetch(32'h0000_4501);
        drain();
        check("pc_after_a", 64'(o_instr_pc), 64'h108);

`ifdef FROST_RVC_EN
        // Spanning instruction with the second word withheld for three cycles
        redirect(32'h0000_0200);
        push(32'h0000_4501, 32'h0000_0200, 1'b1, 1'b0);
        fetch(32'h0513_4501);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge i_clk);
            seen = o_spanning_wait_for_fetch;
        end
        check("span_wait_seen", 64'(seen), 64'd1);
        tick();
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            check("span_wait", 64'(o_spanning_wait_for_fetch), 64'd1);
            check("span_wait_valid", 64'(o_instr_valid), 64'd0);
            check("span_wait_ready", 64'(o_fetch_ready), 64'd1);
            tick();
        end
        push(32'h00A3_0513, 32'h0000_0202, 1'b0, 1'b1);
        push(32'h0000_1234, 32'h0000_0206, 1'b1, 1'b0);
        fetch(32'h1234_00A3);
        @(negedge i_clk);
        check("span_in_progress", 64'(o_spanning_in_progress), 64'd1);
        tick();
        drain();
`endif

        // Back-to-back 32-bit words
        redirect(32'h0000_0400);
        for (int k = 0; k < 4; k++) push(b2b_words[k], 32'h400 + 32'(4 * k), 1'b0, 1'b0);
        i_fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_fetch_word = b2b_words[k];
            @(negedge i_clk);
            check("b2b_fetch_ready", 64'(o_fetch_ready), 64'd1);
            if (k > 0) check("b2b_instr_valid", 64'(o_instr_valid), 64'd1);
            tick();
        end
        i_fetch_valid = 1'b0;
        drain();

        // Downstream stall with a pending instruction, then redirect during the stall
        i_instr_ready = 1'b0;
`ifdef FROST_RVC_EN
        redirect(32'h0000_0302);
        fetch(32'h0513_4501);
        fetch(32'h1234_00A3);
        for (int j = 0; j < 5; j++) begin
            @(negedge i_clk);
            check("stall_valid", 64'(o_instr_valid), 64'd1);
            check("stall_instr", 64'(o_instr), 64'h00A3_0513);
            check("stall_pc", 64'(o_instr_pc), 64'h302);
            check("stall_span", 64'(o_spanning_in_progress), 64'd1);
            check("stall_fetch_ready", 64'(o_fetch_ready), 64'd0);
            tick();
        end
`else
        redirect(32'h0000_0300);
        fetch(32'h0050_0293);
        for (int j = 0; j < 5; j++) begin
            @(negedge i_clk);
            check("stall_valid", 64'(o_instr_valid), 64'd1);
            check("stall_instr", 64'(o_instr), 64'h0050_0293);
            check("stall_pc", 64'(o_instr_pc), 64'h300);
            check("stall_fetch_ready", 64'(o_fetch_ready), 64'd0);
            tick();
        end
`endif
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0500;
        @(negedge i_clk);
        check("redir_cycle_valid", 64'(o_instr_valid), 64'd0);
        check("redir_cycle_ready", 64'(o_fetch_ready), 64'd0);
        tick();
        i_redirect = 1'b0;
        @(negedge i_clk);
        check("post_redir_valid", 64'(o_instr_valid), 64'd0);
        check("post_redir_ready", 64'(o_fetch_ready), 64'd1);
        check("post_redir_pc", 64'(o_instr_pc), 64'h500);
        tick();
        i_instr_ready = 1'b1;

        // pc wrap-around
        redirect(32'hFFFF_FFFC);
        push(32'h0010_0093, 32'hFFFF_FFFC, 1'b0, 1'b0);
        fetch(32'h0010_0093);
        drain();
        check("pc_wrap", 64'(o_instr_pc), 64'h0);

        // Halfword redirect target
        redirect(32'h0000_0102);
`ifdef FROST_RVC_EN
        @(negedge i_clk);
        check("rvc_misaligned", 64'(o_misaligned), 64'd0);
        check("rvc_halfword_ready", 64'(o_fetch_ready), 64'd1);
        tick();
`else
        i_fetch_valid = 1'b1;
        i_fetch_word  = 32'h0010_0093;
        for (int j = 0; j < 3; j++) begin
            @(negedge i_clk);
            check("misaligned", 64'(o_misaligned), 64'd1);
            check("misaligned_ready", 64'(o_fetch_ready), 64'd0);
            check("misaligned_valid", 64'(o_instr_valid), 64'd0);
            tick();
        end
        i_fetch_valid = 1'b0;
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
